// File: rtl/uart_txq_pkg.sv
// Shared constants for the UART transmit queue: FSM encoding, defaults, helpers.
package uart_txq_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD     = 115_200;
  localparam int unsigned DEFAULT_DEPTH    = 16;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned BIT_W   = 3;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_START = 2'd1;
  localparam logic [STATE_W-1:0] ST_DATA  = 2'd2;
  localparam logic [STATE_W-1:0] ST_STOP  = 2'd3;

  localparam logic [BIT_W-1:0] LAST_DATA_BIT = 3'd7;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/txq_fifo.sv
// Single-clock byte FIFO with wrap-around pointers and an extra MSB for full/empty.
module txq_fifo
  import uart_txq_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned DW    = BYTE_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [DW-1:0]          data_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          head_c_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push_c;
  logic          do_pop_c;

  // Next pointers and status; full is judged on the pre-edge occupancy.
  always_comb begin
    do_push_c = push_i && !full_q;
    do_pop_c  = pop_i && !empty_q;
    wptr_d    = wptr_q + PW'(do_push_c);
    rptr_d    = rptr_q + PW'(do_pop_c);
    level_d   = wptr_d - rptr_d;
    empty_d   = (wptr_d == rptr_d);
    full_d    = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  end

  // Pointer and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push_c) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

  assign head_c_o = mem_q[rptr_q[AW-1:0]];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign level_o  = level_q;

endmodule

// File: rtl/uart_txq.sv
// Bus-fed UART transmitter: byte FIFO drained by an 8N1 serializer.
module uart_txq
  import uart_txq_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD     = DEFAULT_BAUD,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   uartEn_i,
  input  logic                   uartWen_i,
  input  logic [7:0]             uartWData_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   busy_o,
  output logic                   overflow_o,
  output logic                   uart_txd
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = cnt_width(DIV);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;

  logic               wr_req_c;
  logic               pop_c;
  logic               bit_end_c;
  logic [BYTE_W-1:0]  head_c;
  logic               fifo_full;
  logic               fifo_empty;

  assign wr_req_c = uartEn_i && uartWen_i;

  txq_fifo #(
    .DEPTH (DEPTH),
    .DW    (BYTE_W)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_i),
    .push_i   (wr_req_c),
    .data_i   (uartWData_i),
    .pop_i    (pop_c),
    .head_c_o (head_c),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .level_o  (level_o)
  );

  // Serializer next state: each line bit is held for exactly DIV clocks.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop_c     = 1'b0;
    bit_end_c = (cnt_q == CW'(DIV - 1));

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_START;
          pop_c   = 1'b1;
          shift_d = head_c;
          txd_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[BYTE_W-1:1]};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          cnt_d = '0;
          if (bit_q == LAST_DATA_BIT) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[BYTE_W-1:1]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    overflow_d = overflow_q || (wr_req_c && fifo_full);
  end

  // Serializer and status registers; reset aborts any frame with the line high.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign full_o     = fifo_full;
  assign empty_o    = fifo_empty;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;
  assign uart_txd   = txd_q;

endmodule

// File: tb/tb_uart_txq.sv
// Randomized + directed bench for uart_txq with a queue-based line scoreboard.
module tb_uart_txq;

  localparam int DEPTH = 16;
  localparam int DIV   = 10;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       wen = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       full_o, empty_o, busy_o, overflow_o, uart_txd;
  logic [4:0] level_o;

  uart_txq #(
    .CLK_FREQ (1000000),
    .BAUD     (100000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .uartEn_i    (en),
    .uartWen_i   (wen),
    .uartWData_i (wdata),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .level_o     (level_o),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
    .uart_txd    (uart_txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: bytes accepted but not yet seen on the line.
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         n_push = 0;
  int         n_start = 0;
  logic       model_ovf = 1'b0;
  int         last_wr_cyc = 0;

  int n_cmp = 0;
  int n_fail = 0;

  // Monitor state.
  logic       mon_en = 1'b0;
  logic       mon_active = 1'b0;
  logic       post_frame = 1'b0;
  logic       bit_ok = 1'b1;
  logic [7:0] cur_byte = 8'h00;
  int         bit_idx = 0;
  int         smp = 0;
  int         idle_wait = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL timeout_%s: condition not reached (cycle %0d)", name, cyc);
  endtask

  // Line decoder and status checker, sampled on the falling edge.
  always @(negedge clk) begin
    logic eb;
    if (mon_en) begin
      if (!rst_n) begin
        mon_active = 1'b0;
        post_frame = 1'b0;
        idle_wait  = 0;
        check("reset_outputs", int'({uart_txd, busy_o, full_o, empty_o, overflow_o, level_o}),
              int'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0}));
      end else begin
        if (mon_active) begin
          if (bit_idx == 0) eb = 1'b0;
          else if (bit_idx == 9) eb = 1'b1;
          else eb = cur_byte[bit_idx-1];
          if (uart_txd !== eb || busy_o !== 1'b1) bit_ok = 1'b0;
          smp++;
          if (smp == DIV) begin
            check($sformatf("frame_%02h_bit%0d", cur_byte, bit_idx), int'(bit_ok), 1);
            smp     = 0;
            bit_ok  = 1'b1;
            bit_idx++;
            if (bit_idx == 10) begin
              mon_active = 1'b0;
              post_frame = 1'b1;
            end
          end
        end else if (post_frame) begin
          check("gap_idle_busy_txd", int'({busy_o, uart_txd}), 1);
          post_frame = 1'b0;
          idle_wait  = 0;
        end else if (uart_txd === 1'b0) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_frame: line low with empty model queue (cycle %0d)", cyc);
            cur_byte = 8'h00;
          end else begin
            cur_byte = exp_q.pop_front();
            n_start++;
          end
          check("start_latency", int'(idle_wait > 1), 0);
          start_q.push_back(cyc);
          mon_active = 1'b1;
          bit_idx    = 0;
          smp        = 1;
          bit_ok     = (busy_o === 1'b1);
          idle_wait  = 0;
        end else begin
          check("idle_busy", int'(busy_o), 0);
          if (n_push > n_start) idle_wait++;
        end
        check("level", int'(level_o), n_push - n_start);
        check("empty", int'(empty_o), int'(n_push == n_start));
        check("full", int'(full_o), int'((n_push - n_start) == DEPTH));
        check("overflow", int'(overflow_o), int'(model_ovf));
      end
    end
  end

  // One bus cycle; the model decides acceptance from the pre-edge occupancy.
  task automatic drive(input logic e, input logic w, input logic [7:0] d);
    int lvl;
    en = e; wen = w; wdata = d;
    @(posedge clk);
    #1;
    lvl = n_push - n_start;
    if (e && w) begin
      if (lvl < DEPTH) begin
        exp_q.push_back(d);
        n_push++;
      end else begin
        model_ovf = 1'b1;
      end
      last_wr_cyc = cyc;
    end
    en = 1'b0; wen = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (!(n_push == n_start && !mon_active && !post_frame && busy_o === 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) timeout(name);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int k = 0;
    while (n_start < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) timeout(name);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, n0;
    logic ee, ww;

    // Reset.
    #1 rst_n = 1'b0;
    mon_en = 1'b1;
    #1;
    check("por_txd", int'(uart_txd), 1);
    check("por_level", int'(level_o), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single 0xA5 frame: start at E+1, busy drops at E+101.
    n0 = n_start;
    drive(1'b1, 1'b1, 8'hA5);
    e = last_wr_cyc;
    wait_starts(n0 + 1, 50, "single_start");
    check("single_latency", start_q[$], e + 1);
    wait_until_cyc(e + FRAME);
    check("single_busy_before_end", int'(busy_o), 1);
    @(posedge clk);
    #1;
    check("single_busy_end", int'({busy_o, uart_txd}), 1);
    wait_idle(300, "single_idle");

    // Chip-select without write flag is ignored.
    repeat (5) drive(1'b1, 1'b0, 8'h77);
    check("nonwrite_level", int'(level_o), 0);
    repeat (20) drive(1'b0, 1'b0, 8'h00);
    check("nonwrite_txd", int'(uart_txd), 1);
    check("nonwrite_no_frame", n_start, n0 + 1);

    // Back-to-back frames.
    n0 = n_start;
    drive(1'b1, 1'b1, 8'h3C);
    drive(1'b1, 1'b1, 8'hC3);
    wait_starts(n0 + 2, 400, "b2b_starts");
    check("b2b_spacing", start_q[$] - start_q[$-1], FRAME + 1);
    wait_idle(300, "b2b_idle");

    // Push coinciding with the pop at level 3.
    n0 = n_start;
    drive(1'b1, 1'b1, 8'h11);
    wait_starts(n0 + 1, 50, "pp_start");
    s = start_q[$];
    drive(1'b1, 1'b1, 8'h22);
    drive(1'b1, 1'b1, 8'h33);
    drive(1'b1, 1'b1, 8'h44);
    check("pp_level_before", int'(level_o), 3);
    wait_until_cyc(s + FRAME);
    drive(1'b1, 1'b1, 8'h55);
    check("pp_same_edge", last_wr_cyc, s + FRAME + 1);
    check("pp_level_after", int'(level_o), 3);
    wait_idle(800, "pp_idle");

    // Burst of 17 while a frame is in flight, so nothing is popped during it.
    check("pre_burst_ovf", int'(overflow_o), 0);
    n0 = n_start;
    drive(1'b1, 1'b1, 8'hEE);
    wait_starts(n0 + 1, 50, "burst_start");
    for (int i = 0; i <= 16; i++) drive(1'b1, 1'b1, 8'(i));
    check("burst_full", int'(full_o), 1);
    check("burst_level", int'(level_o), DEPTH);
    check("burst_ovf", int'(overflow_o), 1);
    wait_idle((DEPTH + 2) * (FRAME + 1) + 100, "burst_drain");

    // Random bus traffic.
    for (int i = 0; i < 2000; i++) begin
      ee = ($urandom_range(0, 29) == 0);
      ww = ee ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      drive(ee, ww, 8'($urandom));
    end
    wait_idle((DEPTH + 2) * (FRAME + 1) + 100, "random_drain");

    // Reset during data bit 4 with bytes still queued.
    n0 = n_start;
    drive(1'b1, 1'b1, 8'h0F);
    wait_starts(n0 + 1, 50, "rst_start");
    s = start_q[$];
    drive(1'b1, 1'b1, 8'h01);
    drive(1'b1, 1'b1, 8'h02);
    wait_until_cyc(s + DIV + 4 * DIV + 3);
    check("rst_pre_txd", int'(uart_txd), 0);
    rst_n = 1'b0;
    exp_q.delete();
    n_push = 0;
    n_start = 0;
    model_ovf = 1'b0;
    #1;
    check("rst_async_txd", int'(uart_txd), 1);
    check("rst_async_level", int'(level_o), 0);
    check("rst_async_ovf", int'(overflow_o), 0);
    check("rst_async_empty", int'(empty_o), 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_release_txd", int'(uart_txd), 1);
    repeat (300) drive(1'b0, 1'b0, 8'h00);
    check("rst_no_frame", n_start, 0);

    // New write after reset.
    drive(1'b1, 1'b1, 8'h96);
    e = last_wr_cyc;
    wait_starts(1, 50, "post_rst_start");
    check("post_rst_latency", start_q[$], e + 1);
    wait_idle(300, "post_rst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
